// File: rtl/store_buffer_mem.sv
// Store buffer for the memory stage: holds committed stores in a circular FIFO,
// drains them in order to the data bus with one outstanding request, merges
// same-word stores into the youngest idle entry and forwards buffered bytes
// to younger loads.
module store_buffer_mem #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned AW       = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned COALESCE = 1
) (
    input  logic                       clk,
    input  logic                       start,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [XLEN-1:0]            st_data,
    input  logic [XLEN/8-1:0]          st_be,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    input  logic [XLEN/8-1:0]          ld_be,
    output logic                       ld_hit,
    output logic [XLEN-1:0]            ld_data,
    output logic                       ld_stall,
    input  logic                       drain_req,
    output logic                       drained,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [AW-1:0]              mem_req_addr,
    output logic [XLEN-1:0]            mem_req_data,
    output logic [XLEN/8-1:0]          mem_req_be,
    input  logic                       mem_resp_valid,
    input  logic                       mem_resp_err,
    output logic                       fault_valid,
    output logic [AW-1:0]              fault_addr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [NB-1:0]   be_q   [DEPTH];
    logic [PW-1:0]   head, tail, youngest;
    logic [CW-1:0]   count_next;
    logic            accept, merge, push, pop;
    logic            fwd_found, fwd_cover;
    logic [PW-1:0]   fwd_idx, scan_idx;
    logic            ld_unused;

    // Byte-offset bits of the load address play no part in word matching.
    assign ld_unused = ^ld_addr[OFF-1:0];

    // Enqueue is blocked while held in reset, when full, or while draining.
    assign st_ready = start && (count < CW'(DEPTH)) && !drain_req;

    // Enqueue/merge/pop decisions and the resulting occupancy.
    // The youngest entry may absorb a store unless it is the head already
    // handed to the drain FSM (its fields must stay stable on the bus).
    always_comb begin
        accept   = st_valid && st_ready;
        youngest = tail - PW'(1);
        merge    = 1'b0;
        if ((COALESCE != 0) && accept && (count != '0)
            && (addr_q[youngest][AW-1:OFF] == st_addr[AW-1:OFF])
            && !((state != IDLE) && (youngest == head)))
            merge = 1'b1;
        push       = accept && !merge;
        pop        = (state == WAIT) && mem_resp_valid;
        count_next = count + CW'(push) - CW'(pop);
    end

    // Drain FSM next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (count != '0) state_next = REQ;
            REQ:  if (mem_req_ready) state_next = WAIT;
            WAIT: if (mem_resp_valid) state_next = (count_next != '0) ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, pointers, occupancy and the registered fault pulse.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fault_valid <= 1'b0;
            fault_addr  <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            fault_valid <= pop && mem_resp_err;
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            if (pop && mem_resp_err) fault_addr <= addr_q[head];
        end
    end

    // Entry storage: new entry at the tail, or byte merge into the youngest.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
            be_q[tail]   <= st_be;
        end else if (merge) begin
            for (int unsigned b = 0; b < NB; b++)
                if (st_be[b]) data_q[youngest][8*b +: 8] <= st_data[8*b +: 8];
            be_q[youngest] <= be_q[youngest] | st_be;
        end
    end

    // Bus request and drain status.
    always_comb begin
        mem_req_valid = (state == REQ);
        mem_req_addr  = '0;
        mem_req_data  = '0;
        mem_req_be    = '0;
        if (mem_req_valid) begin
            mem_req_addr = addr_q[head];
            mem_req_data = data_q[head];
            mem_req_be   = be_q[head];
        end
        drained = (count == '0) && (state == IDLE);
    end

    // Load forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_found = 1'b0;
        fwd_idx   = head;
        scan_idx  = head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if ((CW'(k) < count) && (addr_q[scan_idx][AW-1:OFF] == ld_addr[AW-1:OFF])) begin
                fwd_found = 1'b1;
                fwd_idx   = scan_idx;
            end
        end
        fwd_cover = ((be_q[fwd_idx] & ld_be) == ld_be);
        ld_hit    = ld_valid && fwd_found && fwd_cover;
        ld_stall  = ld_valid && fwd_found && !fwd_cover;
        ld_data   = '0;
        if (ld_hit) begin
            for (int unsigned b = 0; b < NB; b++)
                if (ld_be[b]) ld_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
        end
    end

endmodule

// File: tb/tb_store_buffer_mem.sv
// Bench for store_buffer_mem: directed table of forwarding cases, hand-written
// multi-cycle sequences, and a randomized run against a queue-based model.
module tb_store_buffer_mem;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        start;
    logic        st_valid, ld_valid, drain_req;
    logic [31:0] st_addr, st_data, ld_addr;
    logic [3:0]  st_be, ld_be;
    logic        st_ready, ld_hit, ld_stall, drained;
    logic [31:0] ld_data;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_err;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [3:0]  mem_req_be;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic [2:0]  count;

    store_buffer_mem #(.XLEN(32), .AW(32), .DEPTH(DEPTH), .COALESCE(1)) dut (
        .clk(clk), .start(start),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .drain_req(drain_req), .drained(drained),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_be(mem_req_be),
        .mem_resp_valid(mem_resp_valid), .mem_resp_err(mem_resp_err),
        .fault_valid(fault_valid), .fault_addr(fault_addr), .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (start) assert (!(st_valid && ld_valid)) else $error("store and load requested together");

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [3:0]  be;
        logic        hit;
        logic        stall;
        logic [31:0] d;
    } fv_t;

    int total = 0;
    int bad   = 0;

    // Bench-side memory: one outstanding write, response after a random latency.
    bit          outst;
    int          lat;
    bit          err_plan;
    int          rdy_pct, max_lat, err_pct;
    logic [31:0] err_addr;
    ent_t        reqs[$];
    int          pops;

    // Reference model state.
    ent_t        mq[$];
    bit          busy;
    bit          fpend;
    logic [31:0] faddr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_drive();
        mem_resp_valid = outst && (lat == 0);
        mem_resp_err   = mem_resp_valid && err_plan;
        mem_req_ready  = (int'($urandom_range(0, 99)) < rdy_pct);
    endtask

    task automatic bus_edge();
        bit   acc;
        ent_t e;
        acc  = mem_req_valid && mem_req_ready;
        e.a  = mem_req_addr;
        e.d  = mem_req_data;
        e.be = mem_req_be;
        @(posedge clk);
        if (mem_resp_valid) begin
            outst = 1'b0;
            pops++;
        end else if (outst) begin
            lat--;
        end
        if (acc) begin
            outst    = 1'b1;
            lat      = int'($urandom_range(0, max_lat));
            err_plan = (e.a == err_addr) || (int'($urandom_range(0, 99)) < err_pct);
            reqs.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        st_valid = 1'b0; ld_valid = 1'b0; drain_req = 1'b0;
        st_addr = '0; st_data = '0; st_be = '0; ld_addr = '0; ld_be = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        outst = 1'b0; lat = 0; err_plan = 1'b0; pops = 0;
        reqs.delete();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic exp_rdy);
        st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
        bus_drive();
        #3 chk("st_ready", st_ready, exp_rdy);
        bus_edge();
        st_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        bus_drive();
        #3;
        bus_edge();
    endtask

    initial begin
        fv_t  fv[9];
        ent_t exp_req[4];
        bit   seen;
        int   op;
        bit   exp_rdy, exp_hit, exp_stall, found, pop, fpend_n, was_nonempty;
        logic [31:0] exp_d, faddr_n;
        ent_t t;

        fv[0] = '{1'b1, 32'h1002, 4'b1100, 1'b1, 1'b0, 32'hAABB0000};
        fv[1] = '{1'b1, 32'h1000, 4'b1111, 1'b1, 1'b0, 32'hAABBCCDD};
        fv[2] = '{1'b1, 32'h2000, 4'b1111, 1'b0, 1'b1, 32'h00000000};
        fv[3] = '{1'b1, 32'h2000, 4'b0001, 1'b1, 1'b0, 32'h00000066};
        fv[4] = '{1'b1, 32'h3000, 4'b0011, 1'b1, 1'b0, 32'h00002211};
        fv[5] = '{1'b1, 32'h3000, 4'b0100, 1'b0, 1'b1, 32'h00000000};
        fv[6] = '{1'b1, 32'h4000, 4'b1111, 1'b0, 1'b0, 32'h00000000};
        fv[7] = '{1'b1, 32'h2003, 4'b0010, 1'b1, 1'b0, 32'h00005500};
        fv[8] = '{1'b0, 32'h1000, 4'b1111, 1'b0, 1'b0, 32'h00000000};
        exp_req[0] = '{32'h1000, 32'hAABBCCDD, 4'hF};
        exp_req[1] = '{32'h2000, 32'h00005566, 4'h3};
        exp_req[2] = '{32'h3000, 32'h00002211, 4'h3};
        exp_req[3] = '{32'h5000, 32'h55667788, 4'hF};

        rdy_pct = 0; max_lat = 0; err_pct = 0; err_addr = '1;

        // Values held during reset.
        start = 1'b0;
        st_valid = 1'b0; ld_valid = 1'b0; drain_req = 1'b0;
        st_addr = '0; st_data = '0; st_be = '0; ld_addr = '0; ld_be = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        @(posedge clk);
        #3;
        chk("rst_count", count, 0);
        chk("rst_st_ready", st_ready, 0);
        chk("rst_drained", drained, 1);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_fault", fault_valid, 0);
        chk("rst_ld_hit", ld_hit, 0);
        chk("rst_ld_stall", ld_stall, 0);
        do_reset();

        // Fill with the bus stalled; the two 0x3000 stores merge behind the head.
        do_store(32'h1000, 32'hAABBCCDD, 4'hF, 1'b1);
        do_store(32'h2000, 32'h00005566, 4'h3, 1'b1);
        do_store(32'h3000, 32'h00000011, 4'h1, 1'b1);
        do_store(32'h3000, 32'h00002200, 4'h2, 1'b1);
        bus_drive();
        #3 chk("coalesce_count", count, 3);
        chk("req_head_held", mem_req_addr, 32'h1000);
        bus_edge();

        for (int i = 0; i < 9; i++) begin
            ld_valid = fv[i].v; ld_addr = fv[i].a; ld_be = fv[i].be;
            bus_drive();
            #3;
            chk($sformatf("fwd%0d_hit", i), ld_hit, fv[i].hit);
            chk($sformatf("fwd%0d_stall", i), ld_stall, fv[i].stall);
            chk($sformatf("fwd%0d_data", i), ld_data, fv[i].d);
            bus_edge();
        end
        ld_valid = 1'b0;

        do_store(32'h5000, 32'h55667788, 4'hF, 1'b1);
        do_store(32'h6000, 32'h00000099, 4'hF, 1'b0);
        bus_drive();
        #3 chk("full_count", count, 4);
        chk("full_st_ready", st_ready, 0);
        bus_edge();

        // Release the bus; the partial-overlap load stalls until 0x2000 drains.
        rdy_pct = 100; max_lat = 0;
        ld_valid = 1'b1; ld_addr = 32'h2000; ld_be = 4'hF;
        for (int c = 0; c < 40 && pops < 4; c++) begin
            bus_drive();
            #3;
            chk("drain_stall", ld_stall, (pops < 2));
            chk("drain_hit", ld_hit, 0);
            bus_edge();
        end
        ld_valid = 1'b0;
        chk("drain_pops", pops, 4);
        chk("drain_req_count", reqs.size(), 4);
        for (int i = 0; i < reqs.size() && i < 4; i++) begin
            chk($sformatf("order%0d_addr", i), reqs[i].a, exp_req[i].a);
            chk($sformatf("order%0d_data", i), reqs[i].d, exp_req[i].d);
            chk($sformatf("order%0d_be", i), reqs[i].be, exp_req[i].be);
        end
        bus_drive();
        #3 chk("drain_count", count, 0);
        chk("drain_drained", drained, 1);
        bus_edge();

        // Fault on the first of two stores; the second request follows at once.
        do_reset();
        rdy_pct = 100; max_lat = 0; err_addr = 32'h4000;
        do_store(32'h4000, 32'h00000001, 4'hF, 1'b1);
        do_store(32'h4100, 32'h00000002, 4'hF, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            bus_drive();
            #3;
            if (mem_resp_valid && mem_resp_err) seen = 1'b1;
            chk("err_pre_fault", fault_valid, 0);
            bus_edge();
        end
        chk("err_seen", seen, 1);
        bus_drive();
        #3;
        chk("err_fault_valid", fault_valid, 1);
        chk("err_fault_addr", fault_addr, 32'h4000);
        chk("err_next_req", mem_req_valid, 1);
        chk("err_next_addr", mem_req_addr, 32'h4100);
        bus_edge();
        bus_drive();
        #3 chk("err_fault_pulse", fault_valid, 0);
        bus_edge();
        err_addr = '1;
        for (int c = 0; c < 20 && !drained; c++) idle_cycle();
        bus_drive();
        #3 chk("err_drained", drained, 1);
        bus_edge();

        // Asynchronous reset while waiting on a response under drain_req.
        do_reset();
        rdy_pct = 0;
        do_store(32'h7000, 32'h1, 4'hF, 1'b1);
        do_store(32'h7100, 32'h2, 4'hF, 1'b1);
        do_store(32'h7200, 32'h3, 4'hF, 1'b1);
        drain_req = 1'b1; rdy_pct = 100; max_lat = 50;
        for (int c = 0; c < 10 && !outst; c++) idle_cycle();
        bus_drive();
        #3 chk("ar_pre_count", count, 3);
        chk("ar_pre_req", mem_req_valid, 0);
        #2 start = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_req_valid", mem_req_valid, 0);
        chk("ar_drained", drained, 1);
        chk("ar_fault", fault_valid, 0);
        outst = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_req_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        #3 chk("ar_drain_st_ready", st_ready, 0);
        chk("ar_post_drained", drained, 1);
        drain_req = 1'b0;
        #1 chk("ar_release_st_ready", st_ready, 1);

        // Randomized traffic against the queue model.
        do_reset();
        mq.delete(); busy = 1'b0; fpend = 1'b0; faddr = '0;
        rdy_pct = 60; max_lat = 3; err_pct = 15;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if ($urandom_range(0, 99) < 3) drain_req = !drain_req;
            op       = int'($urandom_range(0, 9));
            st_valid = (op < 4);
            ld_valid = (op >= 4) && (op < 7);
            st_addr  = 32'h100 + 32'(4 * $urandom_range(0, 3));
            st_data  = $urandom;
            st_be    = 4'($urandom_range(1, 15));
            ld_addr  = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            ld_be    = 4'($urandom_range(1, 15));
            bus_drive();
            #3;
            exp_rdy = (mq.size() < DEPTH) && !drain_req;
            chk("rnd_st_ready", st_ready, exp_rdy);
            chk("rnd_count", count, mq.size());
            chk("rnd_drained", drained, (mq.size() == 0));
            chk("rnd_req_valid", mem_req_valid, busy && !outst);
            if (busy && !outst && mq.size() > 0) begin
                chk("rnd_req_addr", mem_req_addr, mq[0].a);
                chk("rnd_req_data", mem_req_data, mq[0].d);
                chk("rnd_req_be", mem_req_be, mq[0].be);
            end
            exp_hit = 1'b0; exp_stall = 1'b0; exp_d = '0; found = 1'b0;
            if (ld_valid) begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (!found && mq[i].a[31:2] == ld_addr[31:2]) begin
                        found = 1'b1;
                        if ((mq[i].be & ld_be) == ld_be) begin
                            exp_hit = 1'b1;
                            for (int b = 0; b < 4; b++)
                                if (ld_be[b]) exp_d[8*b +: 8] = mq[i].d[8*b +: 8];
                        end else begin
                            exp_stall = 1'b1;
                        end
                    end
                end
            end
            chk("rnd_ld_hit", ld_hit, exp_hit);
            chk("rnd_ld_stall", ld_stall, exp_stall);
            chk("rnd_ld_data", ld_data, exp_d);
            chk("rnd_fault_valid", fault_valid, fpend);
            if (fpend) chk("rnd_fault_addr", fault_addr, faddr);

            was_nonempty = (mq.size() > 0);
            pop     = mem_resp_valid && (mq.size() > 0);
            fpend_n = pop && mem_resp_err;
            faddr_n = (mq.size() > 0) ? mq[0].a : faddr;
            if (st_valid && exp_rdy) begin
                if (mq.size() > 0 && mq[mq.size()-1].a[31:2] == st_addr[31:2]
                    && !(busy && mq.size() == 1)) begin
                    t = mq[mq.size()-1];
                    for (int b = 0; b < 4; b++)
                        if (st_be[b]) t.d[8*b +: 8] = st_data[8*b +: 8];
                    t.be = t.be | st_be;
                    mq[mq.size()-1] = t;
                end else begin
                    mq.push_back('{st_addr, st_data, st_be});
                end
            end
            if (pop) void'(mq.pop_front());
            if (!busy) busy = was_nonempty;
            else if (pop && mq.size() == 0) busy = 1'b0;
            if (fpend_n) faddr = faddr_n;
            fpend = fpend_n;
            bus_edge();
        end

        st_valid = 1'b0; ld_valid = 1'b0; drain_req = 1'b1;
        for (int c = 0; c < 200 && !drained; c++) idle_cycle();
        bus_drive();
        #3 chk("final_drained", drained, 1);
        chk("final_count", count, 0);
        chk("final_st_ready", st_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
